switch_fabric_buf: RTL and testbench

//  Parametrised, buffered successor to the combinational switch fabric. Each cycle it

---
 rtl/switch_fabric_buf_if.sv | 29 ++
 rtl/switch_fabric_buf.sv | 119 +++++++++++
 tb/tb_switch_fabric_buf.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_fabric_buf_if.sv
// Bundle of signals between the input arbiter, the buffered switch fabric
// and the per-port egress logic. The arbiter/egress side is the master and
// the fabric is the slave.
interface switch_fabric_buf_if #(
    parameter int NPORTS = 8,
    parameter int DW     = 32,
    parameter int AW     = 4,
    parameter int CNT_W  = 16
);
    logic [NPORTS-1:0][DW-1:0] din;
    logic [NPORTS-1:0][AW-1:0] addr;
    logic [NPORTS-1:0]         grant;
    logic                      accept;
    logic [NPORTS-1:0][DW-1:0] dout;
    logic [NPORTS-1:0]         dout_vld;
    logic [NPORTS-1:0]         dout_rdy;
    logic [CNT_W-1:0]          drop_cnt;
    logic                      grant_err;

    modport master (
        output din, addr, grant, dout_rdy,
        input  accept, dout, dout_vld, drop_cnt, grant_err
    );

    modport slave (
        input  din, addr, grant, dout_rdy,
        output accept, dout, dout_vld, drop_cnt, grant_err
    );
endinterface

// File: rtl/switch_fabric_buf.sv
// Buffered switch fabric: routes at most one granted input word per cycle
// into a per-output FIFO selected by the word's address. Each FIFO drains
// through a valid/ready handshake. Words with an out-of-range address are
// dropped and counted; a multi-hot grant is flagged and ignored.
module switch_fabric_buf #(
    parameter int NPORTS = 8,
    parameter int DW     = 32,
    parameter int AW     = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    switch_fabric_buf_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [DW-1:0]     mem_q    [NPORTS][DEPTH];
    logic [PW-1:0]     wr_ptr_q [NPORTS];
    logic [PW-1:0]     wr_ptr_d [NPORTS];
    logic [PW-1:0]     rd_ptr_q [NPORTS];
    logic [PW-1:0]     rd_ptr_d [NPORTS];
    logic [OW-1:0]     occ_q    [NPORTS];
    logic [OW-1:0]     occ_d    [NPORTS];
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              grant_err_q, grant_err_d;

    logic              one_hot, multi_hot, dest_ok;
    logic [DW-1:0]     sel_din;
    logic [AW-1:0]     sel_addr;
    logic [NPORTS-1:0] full, pop, hit, push;

    // Pointer advance with explicit wrap so non-power-of-two widths stay safe.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign multi_hot = |(bus.grant & (bus.grant - NPORTS'(1)));
    assign one_hot   = (bus.grant != '0) && !multi_hot;
    assign dest_ok   = int'(sel_addr) < NPORTS;

    // Select the granted port's payload and address; only meaningful when one-hot.
    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        sel_din  = '0;
        sel_addr = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (bus.grant[p]) begin
                sel_din  = sel_din | bus.din[p];
                sel_addr = sel_addr | bus.addr[p];
            end
        end
    end

    // Per-output FIFO status, pop/push decisions and next-state pointers.
    always_comb begin
        for (int d = 0; d < NPORTS; d++) begin
            full[d]     = (occ_q[d] == OW'(DEPTH));
            pop[d]      = (occ_q[d] != '0) && bus.dout_rdy[d];
            hit[d]      = one_hot && dest_ok && (int'(sel_addr) == d);
            push[d]     = hit[d] && (!full[d] || pop[d]);
            wr_ptr_d[d] = push[d] ? ptr_inc(wr_ptr_q[d]) : wr_ptr_q[d];
            rd_ptr_d[d] = pop[d]  ? ptr_inc(rd_ptr_q[d]) : rd_ptr_q[d];
            occ_d[d]    = occ_q[d];
            if (push[d] && !pop[d]) occ_d[d] = occ_q[d] + OW'(1);
            if (pop[d] && !push[d]) occ_d[d] = occ_q[d] - OW'(1);
        end
    end

    // Drop counter saturates; grant error is sticky until reset.
    always_comb begin
        drop_cnt_d  = drop_cnt_q;
        if (one_hot && !dest_ok && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        grant_err_d = grant_err_q | multi_hot;
    end

    // Control state: pointers, occupancy, drop counter and error flag.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NPORTS; d++) begin
                wr_ptr_q[d] <= '0;
                rd_ptr_q[d] <= '0;
                occ_q[d]    <= '0;
            end
            drop_cnt_q  <= '0;
            grant_err_q <= 1'b0;
        end else begin
            for (int d = 0; d < NPORTS; d++) begin
                wr_ptr_q[d] <= wr_ptr_d[d];
                rd_ptr_q[d] <= rd_ptr_d[d];
                occ_q[d]    <= occ_d[d];
            end
            drop_cnt_q  <= drop_cnt_d;
            grant_err_q <= grant_err_d;
        end
    end

    // FIFO storage write port.
    // NOTE: the payload memory is not reset; occupancy gates every read, so stale data is never visible.
    always_ff @(posedge clk) begin
        for (int d = 0; d < NPORTS; d++) begin
            if (push[d]) mem_q[d][wr_ptr_q[d]] <= sel_din;
        end
    end

    // Head-of-FIFO outputs, forced to zero while the FIFO is empty.
    always_comb begin
        for (int d = 0; d < NPORTS; d++) begin
            bus.dout_vld[d] = (occ_q[d] != '0);
            bus.dout[d]     = bus.dout_vld[d] ? mem_q[d][rd_ptr_q[d]] : '0;
        end
    end

    assign bus.accept    = one_hot && (!dest_ok || |push);
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.grant_err = grant_err_q;
endmodule

// File: tb/tb_switch_fabric_buf.sv
// Testbench for switch_fabric_buf: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the fabric.
module tb_switch_fabric_buf;
    localparam int NP    = 8;
    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] mq [NP][$];
    int unsigned m_drop;
    logic        m_err;

    switch_fabric_buf_if #(.NPORTS(NP), .DW(32), .AW(4), .CNT_W(16)) bus ();
    switch_fabric_buf_if #(.NPORTS(NP), .DW(32), .AW(4), .CNT_W(2))  bus_s ();

    switch_fabric_buf #(.NPORTS(NP), .DW(32), .AW(4), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    switch_fabric_buf #(.NPORTS(NP), .DW(32), .AW(4), .DEPTH(DEPTH), .CNT_W(2)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < NP; d++) mq[d].delete();
        m_drop = 0;
        m_err  = 1'b0;
    endtask

    // One cycle: inputs already driven at the falling edge. Compare the DUT
    // against the model, advance the model, and move to the next falling edge.
    task automatic step(output logic acc);
        logic [NP-1:0]       exp_vld;
        logic [NP-1:0][31:0] exp_dout;
        logic [NP-1:0]       popm;
        logic                exp_acc;
        logic                do_push;
        int                  gcnt, p, a;
        #1;
        for (int d = 0; d < NP; d++) begin
            exp_vld[d]  = (mq[d].size() != 0);
            exp_dout[d] = exp_vld[d] ? mq[d][0] : 32'h0;
            popm[d]     = exp_vld[d] && bus.dout_rdy[d];
        end
        check("dout_vld", bus.dout_vld, exp_vld);
        check("dout", bus.dout, exp_dout);
        check("drop_cnt", bus.drop_cnt, m_drop);
        check("grant_err", bus.grant_err, m_err);
        gcnt    = $countones(bus.grant);
        exp_acc = 1'b0;
        do_push = 1'b0;
        p = 0;
        a = 0;
        if (gcnt == 1) begin
            for (int d = 0; d < NP; d++) if (bus.grant[d]) p = d;
            a = int'(bus.addr[p]);
            if (a >= NP) begin
                exp_acc = 1'b1;
                if (m_drop < 65535) m_drop++;
            end else if (mq[a].size() < DEPTH || popm[a]) begin
                exp_acc = 1'b1;
                do_push = 1'b1;
            end
        end else if (gcnt > 1) begin
            m_err = 1'b1;
        end
        check("accept", bus.accept, exp_acc);
        acc = bus.accept;
        for (int d = 0; d < NP; d++) if (popm[d]) void'(mq[d].pop_front());
        if (do_push) mq[a].push_back(bus.din[p]);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.grant    = '0;
        bus.addr     = '0;
        bus.din      = '0;
        bus.dout_rdy = '1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic acc;
        rst_n = 1'b0;
        idle_inputs();
        bus_s.grant    = '0;
        bus_s.addr     = '0;
        bus_s.din      = '0;
        bus_s.dout_rdy = '1;
        model_clear();
        #1;
        check("rst_dout_vld", bus.dout_vld, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_drop_cnt", bus.drop_cnt, 0);
        check("rst_grant_err", bus.grant_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturating drop counter on the narrow-counter instance.
        bus_s.grant   = 8'h01;
        bus_s.addr[0] = 4'hF;
        for (int k = 1; k <= 5; k++) begin
            #1;
            check("sat_accept", bus_s.accept, 1);
            @(posedge clk);
            @(negedge clk);
            check("sat_drop_cnt", bus_s.drop_cnt, (k < 3) ? k : 3);
            check("sat_dout_vld", bus_s.dout_vld, 0);
        end
        bus_s.grant = '0;

        // Single word through to port 3, one-cycle latency.
        bus.grant   = 8'h04;
        bus.din[2]  = 32'hA5A5_0001;
        bus.addr[2] = 4'd3;
        step(acc);
        check("t1_accept", acc, 1);
        idle_inputs();
        check("t1_vld", bus.dout_vld, 8'h08);
        check("t1_dout3", bus.dout[3], 32'hA5A5_0001);
        step(acc);
        check("t1_vld_gone", bus.dout_vld, 8'h00);

        // Backpressure on port 5: third word held until a pop frees space.
        bus.dout_rdy[5] = 1'b0;
        bus.grant       = 8'h02;
        bus.addr[1]     = 4'd5;
        for (int v = 1; v <= 3; v++) begin
            bus.din[1] = 32'(v);
            step(acc);
            check("t2_accept", acc, (v < 3) ? 1'b1 : 1'b0);
        end
        check("t2_head_held", bus.dout[5], 32'd1);
        bus.dout_rdy[5] = 1'b1;
        step(acc);
        check("t2_accept_on_pop", acc, 1);
        idle_inputs();
        check("t2_head2", bus.dout[5], 32'd2);
        step(acc);
        check("t2_head3", bus.dout[5], 32'd3);
        step(acc);
        check("t2_empty", bus.dout_vld[5], 0);

        // Full FIFO with simultaneous pop and push.
        bus.dout_rdy[1] = 1'b0;
        bus.grant       = 8'h40;
        bus.addr[6]     = 4'd1;
        bus.din[6]      = 32'h10;
        step(acc);
        bus.din[6]      = 32'h11;
        step(acc);
        bus.dout_rdy[1] = 1'b1;
        bus.din[6]      = 32'h12;
        step(acc);
        check("t3_accept_full_pop", acc, 1);
        idle_inputs();
        check("t3_head", bus.dout[1], 32'h11);
        step(acc);
        check("t3_next", bus.dout[1], 32'h12);
        step(acc);

        // Invalid address drops.
        bus.grant   = 8'h01;
        bus.addr[0] = 4'hF;
        bus.din[0]  = 32'hDEAD;
        for (int k = 0; k < 3; k++) begin
            step(acc);
            check("t4_accept", acc, 1);
        end
        idle_inputs();
        check("t4_drop_cnt", bus.drop_cnt, 3);
        check("t4_no_vld", bus.dout_vld, 0);

        // Multi-hot grant.
        bus.grant   = 8'h11;
        bus.addr[0] = 4'd2;
        bus.addr[4] = 4'd2;
        step(acc);
        check("t5_accept", acc, 0);
        idle_inputs();
        check("t5_grant_err", bus.grant_err, 1);
        check("t5_no_vld", bus.dout_vld, 0);
        for (int k = 0; k < 10; k++) step(acc);
        check("t5_grant_err_sticky", bus.grant_err, 1);

        // Reset mid-stream with two words queued on port 0.
        bus.dout_rdy[0] = 1'b0;
        bus.grant       = 8'h08;
        bus.addr[3]     = 4'd0;
        for (int k = 0; k < 2; k++) begin
            bus.din[3] = 32'h100 + 32'(k);
            step(acc);
        end
        idle_inputs();
        bus.dout_rdy[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_vld_async", bus.dout_vld, 0);
        check("t6_drop_async", bus.drop_cnt, 0);
        check("t6_err_async", bus.grant_err, 0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.dout_rdy = '1;
        bus.grant    = 8'h08;
        bus.din[3]   = 32'hCAFE_0006;
        step(acc);
        check("t6_accept", acc, 1);
        idle_inputs();
        check("t6_vld", bus.dout_vld, 8'h01);
        check("t6_dout0", bus.dout[0], 32'hCAFE_0006);
        step(acc);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) bus.grant = '0;
            else if (r == 1) bus.grant = NP'(1 << $urandom_range(0, 3)) | NP'(1 << $urandom_range(4, 7));
            else bus.grant = NP'(1 << $urandom_range(0, NP - 1));
            for (int p = 0; p < NP; p++) begin
                bus.addr[p] = ($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 8));
                bus.din[p]  = $urandom;
            end
            bus.dout_rdy = NP'($urandom);
            step(acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
